// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Digit geometry and the load-handshake state encoding.
package seg_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 4;
    localparam int SEL_W      = 3;

    typedef logic [DIGIT_W-1:0] digit_t;
    typedef logic [SEL_W-1:0]   sel_t;

    typedef enum logic {
        IDLE,
        PENDING
    } load_state_t;

    localparam sel_t LAST_SEL = sel_t'(NUM_DIGITS - 1);

endpackage

// File: rtl/refresh_prescaler.sv
// Free-running divider producing a one-cycle tick every REFRESH_DIV clocks.
// With REFRESH_DIV == 1 the counter stays at zero and tick is always high.
module refresh_prescaler #(
    parameter int REFRESH_DIV = 100_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign tick = (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit scan driver feeding the hex decoder stage.
// New words wait in a shadow register and commit only at frame boundaries.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100_000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load_valid,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] load_data,
    output logic                          load_ready,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    output digit_t                        num,
    output sel_t                          sel,
    output logic                          blank,
    output logic                          frame_done
);

    logic                          w_tick;
    logic                          w_boundary;
    logic                          w_capture;
    logic                          w_commit;
    load_state_t                   r_state;
    load_state_t                   w_state_nxt;
    sel_t                          r_sel;
    logic [NUM_DIGITS*DIGIT_W-1:0] r_disp;
    logic [NUM_DIGITS*DIGIT_W-1:0] r_shadow;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] w_digits;

    refresh_prescaler #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (w_tick)
    );

    assign w_boundary = w_tick && (r_sel == LAST_SEL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel <= '0;
        end else if (w_tick) begin
            r_sel <= r_sel + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A load arriving on the boundary cycle is only captured here, so it
    // commits at the following boundary rather than the current one.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_commit    = 1'b0;
        load_ready  = 1'b0;
        unique case (r_state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = PENDING;
                end
            end
            PENDING: begin
                if (w_boundary) begin
                    w_commit    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_disp   <= '0;
        end else begin
            if (w_capture) begin
                r_shadow <= load_data;
            end
            if (w_commit) begin
                r_disp <= r_shadow;
            end
        end
    end

    assign w_digits   = r_disp;
    assign num        = w_digits[r_sel];
    assign sel        = r_sel;
    assign blank      = ~digit_en[r_sel];
    assign frame_done = w_boundary;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver with REFRESH_DIV = 4.
// Expected scan position comes from a cycle count; loaded words queue until a boundary.
module tb_seg_scan_driver;

    localparam int DIV   = 4;
    localparam int FRAME = 8 * DIV;

    logic        clk;
    logic        rst_n;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_ready;
    logic [7:0]  digit_en;
    logic [3:0]  num;
    logic [2:0]  sel;
    logic        blank;
    logic        frame_done;

    int          n_checks;
    int          n_errors;
    int          cyc;
    logic [31:0] m_disp;
    logic [31:0] q[$];

    seg_scan_driver #(
        .REFRESH_DIV(DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_valid(load_valid),
        .load_data (load_data),
        .load_ready(load_ready),
        .digit_en  (digit_en),
        .num       (num),
        .sel       (sel),
        .blank     (blank),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t cyc=%0d)",
                     tag, obs, exp, $time, cyc);
        end
    endtask

    // Called at a negedge: compare outputs, drive inputs, advance one clock.
    task automatic step(input logic lv, input logic [31:0] ld);
        int   es;
        logic bound;
        logic accept;
        es = (cyc / DIV) % 8;
        check("sel", sel, es);
        check("num", num, (m_disp >> (4 * es)) & 32'hF);
        check("load_ready", load_ready, q.size() == 0);
        check("frame_done", frame_done, (cyc % FRAME) == FRAME - 1);
        check("blank", blank, !digit_en[es]);
        load_valid = lv;
        load_data  = ld;
        bound  = (cyc % FRAME) == FRAME - 1;
        accept = lv && (q.size() == 0);
        if (bound && q.size() != 0) m_disp = q.pop_front();
        if (accept) q.push_back(ld);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sel"}, sel, 0);
        check({tag, "_num"}, num, 0);
        check({tag, "_ready"}, load_ready, 1);
        check({tag, "_fd"}, frame_done, 0);
        check({tag, "_blank"}, blank, !digit_en[0]);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        load_valid = 1'b0;
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        cyc    = 0;
        m_disp = '0;
        q.delete();
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        cyc        = 0;
        m_disp     = '0;
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        digit_en   = 8'hFF;
        repeat (3) @(negedge clk);
        check_reset_outputs("init");
        rst_n = 1'b1;

        // Idle scanning: sel steps, frame_done pulses, num stays zero
        repeat (FRAME + 8) step(1'b0, '0);

        // Load at cycle 5 after reset, commit at the first boundary
        do_reset();
        repeat (5) step(1'b0, '0);
        step(1'b1, 32'h8765_4321);
        repeat (26 + FRAME) step(1'b0, '0);

        // Offers during PENDING are ignored; re-offer after commit
        step(1'b1, 32'h0F0F_0F0F);
        repeat (10) step(1'b1, 32'hDEAD_BEEF);
        for (int i = 0; i < 2 * FRAME && q.size() != 0; i++)
            step(1'b0, '0);
        step(1'b1, 32'hDEAD_BEEF);
        repeat (2 * FRAME + 4) step(1'b0, '0);

        // Load on the exact boundary cycle from IDLE
        for (int i = 0; i < FRAME && (cyc % FRAME) != FRAME - 1; i++)
            step(1'b0, '0);
        step(1'b1, 32'hAAAA_AAAA);
        check("bnd_disp_unchanged", m_disp, 32'hDEAD_BEEF);
        repeat (2 * FRAME) step(1'b0, '0);

        // Digit mask: upper four digits blanked
        digit_en = 8'h0F;
        repeat (FRAME) step(1'b0, '0);
        for (int i = 0; i < FRAME && (cyc % FRAME) != 1; i++)
            step(1'b0, '0);
        digit_en = 8'h0E;
        #1;
        check("blank_toggle_off", blank, 1);
        step(1'b0, '0);
        digit_en = 8'h0F;
        #1;
        check("blank_toggle_on", blank, 0);
        repeat (FRAME) step(1'b0, '0);

        // Reset while PENDING at sel == 5
        digit_en = 8'hFF;
        for (int i = 0; i < FRAME && (cyc % FRAME) != 0; i++)
            step(1'b0, '0);
        step(1'b1, 32'h1234_5678);
        for (int i = 0; i < FRAME && ((cyc / DIV) % 8) != 5; i++)
            step(1'b0, '0);
        check("pend_before_rst", load_ready, 0);
        #2;
        do_reset();
        repeat (FRAME + 8) step(1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed scan driver for the 8-digit seven-segment display, directly upstream of the combinational hex decoder/anode-select stage. Holds a 32-bit display word (8 hex nibbles), steps a 3-bit digit select at a programmable refresh rate, and presents the current nibble plus select to the decoder. New words are accepted through a valid/ready handshake and committed only at a frame boundary, so the display never shows a half-updated word.

## Interface
- `REFRESH_DIV`, default 100_000: clock cycles each digit is held; legal range ≥1.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load_valid`  in  1  producer offers `load_data`.
- `load_data`  in  32  new display word; nibble k drives digit k (`[3:0]` = digit 0).
- `load_ready`  out  1  shadow register free; a transfer occurs when `load_valid & load_ready`.
- `digit_en`  in  8  per-digit enable mask; 0 blanks that digit.
- `num`  out  4  nibble of the committed word for the current digit; goes to the decoder `num`.
- `sel`  out  3  current digit index; goes to the decoder `sel`.
- `blank`  out  1  1 = current digit masked; top level forces all anodes inactive.
- `frame_done`  out  1  one-cycle pulse on the cycle `sel` wraps 7→0.

## Operation
- Registers: prescaler `cnt` (width `$clog2(REFRESH_DIV)`, min 1), `sel`, committed word `disp`, shadow word `shadow`, flag `pending`.
- Tick: `tick = (cnt == REFRESH_DIV-1)`; on tick `cnt`←0, else `cnt`+1. With `REFRESH_DIV`=1, tick is asserted every cycle.
- On tick, `sel`←`sel`+1, wrapping from 7 to 0.
- Frame boundary: tick while `sel`==7. `frame_done` is high on exactly that cycle.
- Two-state FSM on `pending`:
  - IDLE (`pending`=0, `load_ready`=1): on `load_valid`, `shadow`←`load_data`, go to PENDING.
  - PENDING (`pending`=1, `load_ready`=0): `load_valid` is ignored. At the frame boundary `disp`←`shadow` and the FSM returns to IDLE.
- Simultaneous load and frame boundary in IDLE: the word is captured into `shadow` and committed at the next frame boundary, never the current one.
- `num` = `disp[4*sel +: 4]`, combinational from registers. It changes only when `sel` advances or `disp` commits, and both happen on the same edge.
- `blank` = `~digit_en[sel]`, combinational. A mask change takes effect immediately, without waiting for a boundary.
- No arithmetic beyond the counters. Both wrap silently with no overflow state.

## Timing
- Reset values (async assert, sync release via flops): `cnt`=0, `sel`=0, `disp`=0, `shadow`=0, `pending`=0, `load_ready`=1, `frame_done`=0, `num`=0, `blank`=`~digit_en[0]`.
- Each digit is held for exactly `REFRESH_DIV` cycles. A frame is 8×`REFRESH_DIV` cycles.
- Load latency: handshake edge to `disp` update is between 1 and 8×`REFRESH_DIV` cycles. The update lands on the first frame-boundary edge strictly after the handshake edge.
- `load_ready` falls on the edge after the handshake and rises on the edge after the commit.
- Reset mid-frame or mid-PENDING: the shadow word is discarded, and scanning restarts at digit 0 with `disp`=0.

## Structure
- Package `seg_pkg`:
  - `NUM_DIGITS`=8, `DIGIT_W`=4, `SEL_W`=3.
  - `typedef logic [DIGIT_W-1:0] digit_t`, `typedef logic [SEL_W-1:0] sel_t`.
  - `typedef enum logic {IDLE, PENDING} load_state_t`.
- One sub-module, `refresh_prescaler`: parameter `REFRESH_DIV`; ports `clk`, `rst_n`, `tick`.
- The top level instantiates `seg_scan_driver` ahead of the existing decoder.

## Test plan
All scenarios use `REFRESH_DIV`=4.
1. Reset, hold `load_valid`=0, `digit_en`=8'hFF → `sel` steps 0..7 every 4 cycles, `num`=0, `load_ready`=1, `frame_done` pulses every 32 cycles.
2. Load 32'h8765_4321 at cycle 5 after reset → `load_ready`=0 until the commit at the first boundary (cycle 31 edge). The next frame shows `num`=1,2,…,8 for `sel`=0..7.
3. While PENDING, offer 32'hDEAD_BEEF → ignored, `load_ready` stays 0. After the commit, offer it again → accepted, displayed one frame later.
4. Assert `load_valid` with 32'hAAAA_AAAA on the exact frame-boundary cycle from IDLE → the current frame is unchanged, and the word is committed at the following boundary (32 cycles later).
5. `digit_en`=8'h0F → `blank`=1 exactly while `sel`∈{4..7}. Toggling `digit_en[0]` mid-digit changes `blank` the same cycle.
6. Assert `rst_n`=0 while PENDING at `sel`=5 → outputs return to reset values asynchronously. The pending word never appears on `num`.
